// File: rtl/addr_guard_pkg.sv
// Shared types and helpers for the 8-bit adder residue guard.
package addr_guard_pkg;

    localparam int unsigned RES_W = 2;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        RETRY = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Add two base-4 digits (0..3) and reduce mod 3.
    function automatic res_t res_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        case (s)
            3'd1, 3'd4: res_add = 2'd1;
            3'd2, 3'd5: res_add = 2'd2;
            default:    res_add = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational W-bit to 2-bit mod-3 reducer; 4 == 1 (mod 3), so 2-bit digits are summed.
module mod3_residue
    import addr_guard_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]     x,
    output logic [RES_W-1:0] r
);

    localparam int unsigned NP = (W + 1) / 2;

    logic [2*NP-1:0] xp;
    res_t            acc;

    always_comb begin
        xp         = '0;
        xp[W-1:0]  = x;
        acc        = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            acc = res_add(acc, xp[2*i +: 2]);
        end
    end

    assign r = acc;

endmodule

// File: rtl/addr8u_residue_guard.sv
// Guard stage around an external 8-bit adder: mod-3 residue check, optional retry, fault counter.
// Retry support is compiled in with `define ADDR_GUARD_RETRY_EN.
module addr8u_residue_guard
    import addr_guard_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [8:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    if (MAX_RETRY > 7) begin : g_bad_retry
        $error("MAX_RETRY must be in 0..7");
    end

    state_t           state_q, state_d;
    logic [7:0]       add_a_q, add_a_d;
    logic [7:0]       add_b_q, add_b_d;
    res_t             pr_q, pr_d;
    logic [8:0]       out_sum_q, out_sum_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_inc;
    res_t             res_a, res_b, res_s;

`ifdef ADDR_GUARD_RETRY_EN
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
    logic [2:0] retry_q, retry_d;
`endif

    mod3_residue #(.W(8)) u_res_a (.x(in_a),    .r(res_a));
    mod3_residue #(.W(8)) u_res_b (.x(in_b),    .r(res_b));
    mod3_residue #(.W(9)) u_res_s (.x(add_sum), .r(res_s));

    always_comb begin
        state_d   = state_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        pr_d      = pr_q;
        out_sum_d = out_sum_q;
        out_err_d = out_err_q;
        err_inc   = 1'b0;
`ifdef ADDR_GUARD_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    pr_d    = res_add(res_a, res_b);
`ifdef ADDR_GUARD_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (res_s == pr_q) begin
                    out_sum_d = add_sum;
                    out_err_d = 1'b0;
                    state_d   = HOLD;
`ifdef ADDR_GUARD_RETRY_EN
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 3'd1;
                    state_d = RETRY;
`endif
                end else begin
                    out_sum_d = add_sum;
                    out_err_d = 1'b1;
                    err_inc   = 1'b1;
                    state_d   = HOLD;
                end
            end
`ifdef ADDR_GUARD_RETRY_EN
            RETRY: state_d = EVAL;
`endif
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            pr_q        <= '0;
            out_sum_q   <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
`ifdef ADDR_GUARD_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            pr_q        <= pr_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
`ifdef ADDR_GUARD_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_addr8u_residue_guard.sv
// Directed bench for addr8u_residue_guard; expectations follow ADDR_GUARD_RETRY_EN.
module tb_addr8u_residue_guard;

`ifdef ADDR_GUARD_RETRY_EN
    localparam int RETRY_EN = 1;
`else
    localparam int RETRY_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, err_clr;
    logic [7:0] in_a, in_b;
    logic       ovr_on;
    logic [8:0] ovr_val;

    logic       in_ready, out_valid, out_err;
    logic [7:0] add_a, add_b;
    logic [8:0] add_sum, out_sum;
    logic [7:0] err_count;

    logic       s_in_ready, s_out_valid, s_out_err;
    logic [7:0] s_add_a, s_add_b;
    logic [8:0] s_add_sum, s_out_sum;
    logic [1:0] s_err_count;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    assign add_sum   = ovr_on ? ovr_val : ({1'b0, add_a} + {1'b0, add_b});
    assign s_add_sum = ovr_on ? ovr_val : ({1'b0, s_add_a} + {1'b0, s_add_b});

    addr8u_residue_guard #(.MAX_RETRY(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .err_clr(err_clr), .err_count(err_count)
    );

    addr8u_residue_guard #(.MAX_RETRY(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(s_add_a), .add_b(s_add_b), .add_sum(s_add_sum),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum), .out_err(s_out_err),
        .err_clr(err_clr), .err_count(s_err_count)
    );

    // mode 0: real adder, 1: add_sum stuck at fv, 2: fv only during the first EVAL cycle
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int mode,
                           input logic [8:0] fv, output int lat,
                           output logic [8:0] s, output logic e);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        ovr_val  = fv;
        ovr_on   = (mode != 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (mode == 2) ovr_on = 1'b0;
        end
        s = out_sum;
        e = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ovr_on    = 1'b0;
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready got %b exp 1", in_ready); fails++; end
        tests++;
        if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b exp 0", out_valid); fails++; end
        tests++;
        if (out_err !== 1'b0) begin $display("FAIL rst_out_err got %b exp 0", out_err); fails++; end
        tests++;
        if (out_sum !== 9'h000) begin $display("FAIL rst_out_sum got %h exp 000", out_sum); fails++; end
        tests++;
        if ({add_a, add_b} !== 16'h0000) begin $display("FAIL rst_add_ab got %h exp 0000", {add_a, add_b}); fails++; end
        tests++;
        if (err_count !== 8'd0) begin $display("FAIL rst_err_count got %0d exp 0", err_count); fails++; end
        tests++;
    endtask

    task automatic test_basic();
        int lat; logic [8:0] s; logic e;
        in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if ({add_a, add_b} !== 16'hFF01) begin $display("FAIL basic_add_ab got %h exp ff01", {add_a, add_b}); fails++; end
        tests++;
        if (out_valid !== 1'b0) begin $display("FAIL basic_early_valid got %b exp 0", out_valid); fails++; end
        tests++;
        @(posedge clk); #1;
        if (out_valid !== 1'b1) begin $display("FAIL basic_latency out_valid got %b exp 1", out_valid); fails++; end
        tests++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_txn(8'hFF, 8'h01, 0, 9'h000, lat, s, e);
        if (lat !== 1) begin $display("FAIL basic_lat got %0d exp 1", lat); fails++; end
        tests++;
        if (s !== 9'h100) begin $display("FAIL basic_sum got %h exp 100", s); fails++; end
        tests++;
        if (e !== 1'b0) begin $display("FAIL basic_err got %b exp 0", e); fails++; end
        tests++;
        if (err_count !== exp_cnt) begin $display("FAIL basic_count got %0d exp %0d", err_count, exp_cnt); fails++; end
        tests++;
        if (in_ready !== 1'b1) begin $display("FAIL basic_in_ready got %b exp 1", in_ready); fails++; end
        tests++;
    endtask

    task automatic test_stuck_retry();
        int lat; logic [8:0] s; logic e;
        run_txn(8'h01, 8'h01, 1, 9'h000, lat, s, e);
        exp_cnt++;
        if (lat !== (RETRY_EN ? 5 : 1)) begin $display("FAIL stuck_lat got %0d exp %0d", lat, RETRY_EN ? 5 : 1); fails++; end
        tests++;
        if (s !== 9'h000) begin $display("FAIL stuck_sum got %h exp 000", s); fails++; end
        tests++;
        if (e !== 1'b1) begin $display("FAIL stuck_err got %b exp 1", e); fails++; end
        tests++;
        if (err_count !== exp_cnt) begin $display("FAIL stuck_count got %0d exp %0d", err_count, exp_cnt); fails++; end
        tests++;
    endtask

    task automatic test_retry_recover();
        int lat; logic [8:0] s; logic e;
        run_txn(8'h80, 8'h7F, 2, 9'h0FF, lat, s, e);
        if (lat !== 1 || s !== 9'h0FF || e !== 1'b0) begin
            $display("FAIL recover_ff lat/sum/err got %0d/%h/%b exp 1/0ff/0", lat, s, e); fails++;
        end
        tests++;
        run_txn(8'h80, 8'h7F, 2, 9'h0FE, lat, s, e);
        if (RETRY_EN == 0) exp_cnt++;
        if (lat !== (RETRY_EN ? 3 : 1)) begin $display("FAIL recover_lat got %0d exp %0d", lat, RETRY_EN ? 3 : 1); fails++; end
        tests++;
        if (s !== (RETRY_EN ? 9'h0FF : 9'h0FE)) begin $display("FAIL recover_sum got %h", s); fails++; end
        tests++;
        if (e !== (RETRY_EN ? 1'b0 : 1'b1)) begin $display("FAIL recover_err got %b exp %0d", e, 1 - RETRY_EN); fails++; end
        tests++;
        if (err_count !== exp_cnt) begin $display("FAIL recover_count got %0d exp %0d", err_count, exp_cnt); fails++; end
        tests++;
    endtask

    task automatic test_hold();
        in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        in_a = 8'h55; in_b = 8'h66; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL hold_hs[%0d] valid/ready got %b/%b exp 1/0", i, out_valid, in_ready); fails++;
            end
            tests++;
            if (out_sum !== 9'h046 || out_err !== 1'b0 || add_a !== 8'h12) begin
                $display("FAIL hold_data[%0d] sum/err/add_a got %h/%b/%h exp 046/0/12", i, out_sum, out_err, add_a); fails++;
            end
            tests++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL hold_release valid/ready got %b/%b exp 0/1", out_valid, in_ready); fails++;
        end
        tests++;
        if (add_a !== 8'h12) begin $display("FAIL hold_no_accept add_a got %h exp 12", add_a); fails++; end
        tests++;
    endtask

    task automatic test_saturate();
        int lat; logic [8:0] s; logic e;
        for (int i = 0; i < 4; i++) begin
            run_txn(8'h01, 8'h01, 1, 9'h000, lat, s, e);
            exp_cnt++;
        end
        if (s_err_count !== 2'd3) begin $display("FAIL sat_count got %0d exp 3", s_err_count); fails++; end
        tests++;
        if (err_count !== exp_cnt) begin $display("FAIL sat_wide_count got %0d exp %0d", err_count, exp_cnt); fails++; end
        tests++;
        err_clr = 1'b1;
        run_txn(8'h01, 8'h01, 1, 9'h000, lat, s, e);
        err_clr = 1'b0;
        exp_cnt = 8'd0;
        if (e !== 1'b1) begin $display("FAIL sat_clr_err got %b exp 1", e); fails++; end
        tests++;
        if (s_err_count !== 2'd0) begin $display("FAIL sat_clr_count got %0d exp 0", s_err_count); fails++; end
        tests++;
        if (err_count !== 8'd0) begin $display("FAIL sat_clr_wide got %0d exp 0", err_count); fails++; end
        tests++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [8:0] s; logic e;
        run_txn(8'h01, 8'h01, 1, 9'h000, lat, s, e);
        if (err_count !== 8'd1) begin $display("FAIL mid_pre_count got %0d exp 1", err_count); fails++; end
        tests++;
        in_a = 8'h03; in_b = 8'h04; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        if (out_valid !== 1'b0 || err_count !== 8'd0) begin
            $display("FAIL mid_reset valid/count got %b/%0d exp 0/0", out_valid, err_count); fails++;
        end
        tests++;
        if (in_ready !== 1'b1 || add_a !== 8'h00) begin
            $display("FAIL mid_reset ready/add_a got %b/%h exp 1/00", in_ready, add_a); fails++;
        end
        tests++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL mid_release ready/valid got %b/%b exp 1/0", in_ready, out_valid); fails++;
        end
        tests++;
        run_txn(8'h21, 8'h42, 0, 9'h000, lat, s, e);
        if (lat !== 1 || s !== 9'h063 || e !== 1'b0 || err_count !== 8'd0) begin
            $display("FAIL mid_next lat/sum/err/count got %0d/%h/%b/%0d exp 1/063/0/0", lat, s, e, err_count); fails++;
        end
        tests++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_a = '0; in_b = '0; ovr_on = 1'b0; ovr_val = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_stuck_retry();
        test_retry_recover();
        test_hold();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
